// File: rtl/branch_pkg.sv
// Shared definitions for the branch tracker: default depth, pointer width and
// the tracker's RUN/FLUSH state encoding.
package branch_pkg;

    localparam int DEPTH_DEFAULT = 4;
    localparam int PTR_W_DEFAULT = $clog2(DEPTH_DEFAULT);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/bt_fifo.sv
// Prediction FIFO: one bit per outstanding branch, wrapping pointers, an
// occupancy count and a synchronous clear that overrides push/pop.
module bt_fifo
    import branch_pkg::*;
#(
    parameter  int DEPTH = DEPTH_DEFAULT,
    localparam int PTR_W = ptr_width(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_clear,
    input  logic             i_data,
    output logic             o_head,
    output logic [CNT_W-1:0] o_count
);

    logic [DEPTH-1:0] r_mem;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    // Storage carries no reset; its contents are meaningless until pushed.
    always_ff @(posedge clk) begin
        if (i_push && !i_clear) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(i_push) - CNT_W'(i_pop);
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/branch_tracker.sv
// Tracks predicted branches between fetch and execute, reports training
// results to the predictor and flushes all younger entries on a mispredict.
module branch_tracker
    import branch_pkg::*;
#(
    parameter  int DEPTH = DEPTH_DEFAULT,
    localparam int CNT_W = ptr_width(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             request,
    input  logic             prediction,
    input  logic             resolve_valid,
    input  logic             resolve_taken,
    output logic             result,
    output logic             taken,
    output logic             mispredict,
    output logic             stall,
    output logic [CNT_W-1:0] count,
    output logic             error
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_req_d;
    logic             w_accept;
    logic             w_pop;
    logic             w_push;
    logic             w_mis;
    logic             w_head;
    logic             w_full;
    logic [CNT_W-1:0] w_count;

    bt_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_clear (w_mis),
        .i_data  (prediction),
        .o_head  (w_head),
        .o_count (w_count)
    );

    // Counting the in-flight request keeps its push from overflowing the FIFO.
    assign w_full = (w_count + CNT_W'(r_req_d)) >= CNT_W'(DEPTH);

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = resolve_valid && (w_count != '0) && (r_state == ST_RUN);
        w_mis       = w_pop && (w_head != resolve_taken);
        stall       = (r_state == ST_FLUSH) || w_full;
        case (r_state)
            ST_RUN:   if (w_mis) w_state_nxt = ST_FLUSH;
            ST_FLUSH: w_state_nxt = ST_RUN;
            default:  w_state_nxt = ST_RUN;
        endcase
    end

    assign w_accept = request && !stall;
    assign w_push   = r_req_d && !w_mis;
    assign count    = w_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_RUN;
            r_req_d    <= 1'b0;
            result     <= 1'b0;
            taken      <= 1'b0;
            mispredict <= 1'b0;
            error      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_req_d    <= w_accept;
            result     <= w_pop;
            taken      <= w_pop && resolve_taken;
            mispredict <= w_mis;
            if (resolve_valid && !w_pop) begin
                error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_branch_tracker.sv
// Bench for branch_tracker: directed scenarios plus a random run, all checked
// against a queue-based model of outstanding predictions.
module tb_branch_tracker;

    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             request = 1'b0;
    logic             prediction = 1'b0;
    logic             resolve_valid = 1'b0;
    logic             resolve_taken = 1'b0;
    logic             result;
    logic             taken;
    logic             mispredict;
    logic             stall;
    logic             error;
    logic [CNT_W-1:0] count;

    int n_checks = 0;
    int n_errors = 0;

    // Model: queue of stored predictions, one request possibly in flight.
    bit q[$];
    bit m_inflight;
    bit m_flush;
    bit m_result;
    bit m_taken;
    bit m_mis;
    bit m_err;

    branch_tracker #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .reset         (reset),
        .request       (request),
        .prediction    (prediction),
        .resolve_valid (resolve_valid),
        .resolve_taken (resolve_taken),
        .result        (result),
        .taken         (taken),
        .mispredict    (mispredict),
        .stall         (stall),
        .count         (count),
        .error         (error)
    );

    always #5 clk = ~clk;

    function automatic bit exp_stall();
        return m_flush || ((q.size() + int'(m_inflight)) >= DEPTH);
    endfunction

    task automatic model_reset();
        q.delete();
        m_inflight = 0; m_flush = 0; m_result = 0; m_taken = 0; m_mis = 0; m_err = 0;
    endtask

    task automatic model_edge();
        bit acc, pop, mis;
        acc = request && !exp_stall();
        pop = resolve_valid && (q.size() > 0) && !m_flush;
        mis = pop && (q[0] != resolve_taken);
        m_result = pop;
        m_taken  = pop && resolve_taken;
        m_mis    = mis;
        if (resolve_valid && !pop) m_err = 1;
        if (pop) void'(q.pop_front());
        if (mis) q.delete();
        else if (m_inflight) q.push_back(prediction);
        m_inflight = acc;
        m_flush    = mis;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        request = 0; resolve_valid = 0; resolve_taken = 0; prediction = 0;
        reset = 1;
        @(posedge clk);
        #1;
        reset = 0;
        model_reset();
    endtask

    task automatic test_reset();
        request = 0; resolve_valid = 0;
        reset = 1;
        #2;
        n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL reset_stall: got %0b expected 0", stall); end
        @(posedge clk);
        #1;
        n_checks++; if (count !== '0) begin n_errors++; $display("FAIL reset_count: got %0d expected 0", count); end
        n_checks++; if ({result, taken, mispredict, error} !== 4'b0) begin n_errors++; $display("FAIL reset_outputs: got %b expected 0000", {result, taken, mispredict, error}); end
        reset = 0;
        model_reset();
    endtask

    task automatic test_basic();
        do_reset();
        request = 1;
        tick();
        request = 0; prediction = 1;
        n_checks++; if (count !== CNT_W'(0)) begin n_errors++; $display("FAIL basic_count0: got %0d expected 0", count); end
        tick();
        prediction = 0;
        n_checks++; if (count !== CNT_W'(1)) begin n_errors++; $display("FAIL basic_count1: got %0d expected 1", count); end
        resolve_valid = 1; resolve_taken = 1;
        tick();
        resolve_valid = 0; resolve_taken = 0;
        n_checks++; if ({result, taken, mispredict} !== 3'b110) begin n_errors++; $display("FAIL basic_resolve: got %b expected 110", {result, taken, mispredict}); end
        n_checks++; if (count !== CNT_W'(0)) begin n_errors++; $display("FAIL basic_count2: got %0d expected 0", count); end
        tick();
        n_checks++; if ({result, taken, mispredict} !== 3'b000) begin n_errors++; $display("FAIL basic_pulse: got %b expected 000", {result, taken, mispredict}); end
    endtask

    task automatic test_fill();
        do_reset();
        request = 1;
        for (int i = 0; i < 4; i++) begin
            prediction = 1'($urandom_range(0, 1));
            tick();
        end
        n_checks++; if (stall !== 1'b1) begin n_errors++; $display("FAIL fill_stall: got %0b expected 1", stall); end
        prediction = 1'($urandom_range(0, 1));
        tick();
        tick();
        request = 0;
        n_checks++; if (count !== CNT_W'(DEPTH)) begin n_errors++; $display("FAIL fill_count: got %0d expected %0d", count, DEPTH); end
        n_checks++; if (count !== CNT_W'(q.size())) begin n_errors++; $display("FAIL fill_model: got %0d expected %0d", count, q.size()); end
        while (q.size() > 0) begin
            resolve_valid = 1; resolve_taken = q[0];
            tick();
            n_checks++; if (mispredict !== 1'b0 || result !== 1'b1) begin n_errors++; $display("FAIL fill_drain: got res=%0b mis=%0b expected res=1 mis=0", result, mispredict); end
        end
        resolve_valid = 0;
        tick();
    endtask

    task automatic test_mispredict();
        bit preds [3] = '{1'b0, 1'b1, 1'b1};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            request = (i < 3);
            if (i > 0) prediction = preds[i-1];
            tick();
        end
        request = 0;
        n_checks++; if (count !== CNT_W'(3)) begin n_errors++; $display("FAIL mis_count3: got %0d expected 3", count); end
        resolve_valid = 1; resolve_taken = 1;
        tick();
        resolve_valid = 0; resolve_taken = 0; request = 1;
        n_checks++; if ({result, taken, mispredict} !== 3'b111) begin n_errors++; $display("FAIL mis_outputs: got %b expected 111", {result, taken, mispredict}); end
        n_checks++; if (count !== CNT_W'(0)) begin n_errors++; $display("FAIL mis_flush_count: got %0d expected 0", count); end
        n_checks++; if (stall !== 1'b1) begin n_errors++; $display("FAIL mis_flush_stall: got %0b expected 1", stall); end
        tick();
        n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL mis_run_stall: got %0b expected 0", stall); end
        n_checks++; if (mispredict !== 1'b0) begin n_errors++; $display("FAIL mis_pulse: got %0b expected 0", mispredict); end
        tick();
        request = 0; prediction = 1;
        tick();
        n_checks++; if (count !== CNT_W'(1)) begin n_errors++; $display("FAIL mis_next_accept: got %0d expected 1", count); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        request = 1;
        for (int i = 0; i < 3; i++) begin
            prediction = 1'($urandom_range(0, 1));
            tick();
        end
        n_checks++; if (count !== CNT_W'(2)) begin n_errors++; $display("FAIL b2b_start: got %0d expected 2", count); end
        for (int i = 0; i < 8 * DEPTH; i++) begin
            prediction = 1'($urandom_range(0, 1));
            resolve_valid = 1; resolve_taken = q[0];
            tick();
            n_checks++; if (count !== CNT_W'(2)) begin n_errors++; $display("FAIL b2b_count[%0d]: got %0d expected 2", i, count); end
            n_checks++; if (result !== 1'b1 || mispredict !== 1'b0) begin n_errors++; $display("FAIL b2b_order[%0d]: got res=%0b mis=%0b expected res=1 mis=0", i, result, mispredict); end
        end
        request = 0; resolve_valid = 0;
        tick();
    endtask

    task automatic test_error();
        do_reset();
        resolve_valid = 1; resolve_taken = 1;
        tick();
        resolve_valid = 0;
        n_checks++; if (error !== 1'b1) begin n_errors++; $display("FAIL err_set: got %0b expected 1", error); end
        n_checks++; if (result !== 1'b0 || taken !== 1'b0) begin n_errors++; $display("FAIL err_result: got res=%0b tk=%0b expected 0 0", result, taken); end
        tick();
        tick();
        n_checks++; if (error !== 1'b1) begin n_errors++; $display("FAIL err_sticky: got %0b expected 1", error); end
        n_checks++; if (count !== CNT_W'(0)) begin n_errors++; $display("FAIL err_count: got %0d expected 0", count); end
    endtask

    // Starts from the state test_error leaves, so error is still set here.
    task automatic test_async_reset();
        request = 1;
        for (int i = 0; i < 4; i++) begin
            prediction = 1'($urandom_range(0, 1));
            tick();
        end
        request = 0;
        n_checks++; if (count !== CNT_W'(3)) begin n_errors++; $display("FAIL arst_pre_count: got %0d expected 3", count); end
        resolve_valid = 1; resolve_taken = q[0];
        tick();
        resolve_valid = 0;
        #2;
        reset = 1;
        #1;
        n_checks++; if ({result, taken, mispredict, error, stall} !== 5'b0) begin n_errors++; $display("FAIL arst_outputs: got %b expected 00000", {result, taken, mispredict, error, stall}); end
        n_checks++; if (count !== CNT_W'(0)) begin n_errors++; $display("FAIL arst_count: got %0d expected 0", count); end
        @(posedge clk);
        #1;
        reset = 0;
        model_reset();
        tick();
        n_checks++; if (count !== CNT_W'(0)) begin n_errors++; $display("FAIL arst_push_lost: got %0d expected 0", count); end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            request    = 1'($urandom_range(0, 1));
            prediction = 1'($urandom_range(0, 1));
            if (q.size() > 0) begin
                resolve_valid = ($urandom_range(0, 2) == 0);
                resolve_taken = ($urandom_range(0, 4) == 0) ? !q[0] : q[0];
            end else begin
                resolve_valid = ($urandom_range(0, 29) == 0);
                resolve_taken = 1'($urandom_range(0, 1));
            end
            tick();
            n_checks++; if (count !== CNT_W'(q.size())) begin n_errors++; $display("FAIL rnd_count[%0d]: got %0d expected %0d", i, count, q.size()); end
            n_checks++; if ({result, taken, mispredict} !== {m_result, m_taken, m_mis}) begin n_errors++; $display("FAIL rnd_resolve[%0d]: got %b expected %b", i, {result, taken, mispredict}, {m_result, m_taken, m_mis}); end
            n_checks++; if (stall !== exp_stall()) begin n_errors++; $display("FAIL rnd_stall[%0d]: got %0b expected %0b", i, stall, exp_stall()); end
            n_checks++; if (error !== m_err) begin n_errors++; $display("FAIL rnd_error[%0d]: got %0b expected %0b", i, error, m_err); end
        end
        request = 0; resolve_valid = 0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_fill();
        test_mispredict();
        test_back_to_back();
        test_error();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
